// File: rtl/tcm_port_arb.sv
// Two-requester arbiter in front of a single-port 64-bit TCM, with a zero-fill init sequencer.
// Latency: accept and RAM drive are combinational; read data returns one cycle after accept.
// Backpressure: a requester waits while x_accept_o is low (lost arbitration or init in progress).
module tcm_port_arb #(
    parameter int ADDR_W     = 13,
    parameter int INIT_WORDS = 8192
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [63:0]       a_wdata_i,
    input  logic [7:0]        a_wstrb_i,
    output logic              a_accept_o,
    output logic              a_rvalid_o,
    output logic [63:0]       a_rdata_o,
    input  logic              b_req_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [63:0]       b_wdata_i,
    input  logic [7:0]        b_wstrb_i,
    output logic              b_accept_o,
    output logic              b_rvalid_o,
    output logic [63:0]       b_rdata_o,
    input  logic              init_start_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [63:0]       ram_data_o,
    output logic [7:0]        ram_wr_o,
    input  logic [63:0]       ram_data_i
);

    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_INIT   = 1'b1;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(INIT_WORDS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_b_q, last_b_d;   // 1: B won the most recent grant
    logic              a_rv_q, a_rv_d;
    logic              b_rv_q, b_rv_d;
    logic              done_q, done_d;
    logic              grant_a, grant_b;

    // Round-robin between two requesters; nothing is granted while clearing.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == S_IDLE) begin
            if (a_req_i && (!b_req_i || last_b_q)) begin
                grant_a = 1'b1;
            end else if (b_req_i) begin
                grant_b = 1'b1;
            end
        end
    end

    // RAM port mux: init counter, winning requester, or quiet.
    always_comb begin
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wr_o   = '0;
        if (state_q == S_INIT) begin
            ram_addr_o = cnt_q;
            ram_wr_o   = 8'hFF;
        end else if (grant_a) begin
            ram_addr_o = a_addr_i;
            ram_data_o = a_wdata_i;
            ram_wr_o   = a_wstrb_i;
        end else if (grant_b) begin
            ram_addr_o = b_addr_i;
            ram_data_o = b_wdata_i;
            ram_wr_o   = b_wstrb_i;
        end
    end

    // Next-state: FSM, clear counter, grant history, read-response pipeline.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        done_d   = 1'b0;
        a_rv_d   = grant_a && (a_wstrb_i == 8'h00);
        b_rv_d   = grant_b && (b_wstrb_i == 8'h00);
        if (grant_a) begin
            last_b_d = 1'b0;
        end else if (grant_b) begin
            last_b_d = 1'b1;
        end
        if (state_q == S_IDLE) begin
            if (init_start_i) begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset drops pending responses and any in-flight init.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            a_rv_q   <= 1'b0;
            b_rv_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            a_rv_q   <= a_rv_d;
            b_rv_q   <= b_rv_d;
            done_q   <= done_d;
        end
    end

    assign a_accept_o  = grant_a;
    assign b_accept_o  = grant_b;
    assign a_rvalid_o  = a_rv_q;
    assign b_rvalid_o  = b_rv_q;
    assign a_rdata_o   = a_rv_q ? ram_data_i : 64'h0;
    assign b_rdata_o   = b_rv_q ? ram_data_i : 64'h0;
    assign init_busy_o = (state_q == S_INIT);
    assign init_done_o = done_q;

endmodule

// File: doc/tcm_port_arb.md
TCM_PORT_ARB -- requirements
Module: tcm_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning RAM word-address width.
REQ-002 SHALL have parameter INIT_WORDS, default 8192, meaning number of 64-bit words cleared by an init sequence.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 a_req_i  input  1  requester A access request.
REQ-006 a_addr_i  input  ADDR_W  requester A word address.
REQ-007 a_wdata_i  input  64  requester A write data.
REQ-008 a_wstrb_i  input  8  requester A byte enables; nonzero = write, zero = read.
REQ-009 a_accept_o  output  1  requester A request taken this cycle.
REQ-010 a_rvalid_o  output  1  requester A read data valid.
REQ-011 a_rdata_o  output  64  requester A read data.
REQ-012 b_req_i, b_addr_i, b_wdata_i, b_wstrb_i, b_accept_o, b_rvalid_o, b_rdata_o SHALL mirror REQ-005..REQ-011 for requester B.
REQ-013 init_start_i  input  1  request a zero-fill of words 0..INIT_WORDS-1.
REQ-014 init_busy_o  output  1  init sequence in progress.
REQ-015 init_done_o  output  1  one-cycle pulse at init completion.
REQ-016 ram_addr_o  output  ADDR_W  RAM port word address.
REQ-017 ram_data_o  output  64  RAM port write data.
REQ-018 ram_wr_o  output  8  RAM port byte write enables.
REQ-019 ram_data_i  input  64  RAM port read data, registered, read-first, valid one cycle after address.

Function
REQ-020 SHALL implement FSM states IDLE and INIT; IDLE after reset.
REQ-021 IDLE: at most one request granted per cycle; x_accept_o = x_req_i AND granted, combinational, same cycle.
REQ-022 Arbitration: only one requester -> it wins; both -> the one not granted last; last_grant register updates only on a grant.
REQ-023 Granted request SHALL drive ram_addr_o, ram_data_o, ram_wr_o = x_wstrb_i combinationally in its accept cycle.
REQ-024 No grant (or INIT, see REQ-027): ram_wr_o = 0; ram_addr_o, ram_data_o = 0 in IDLE.
REQ-025 Accepted read SHALL assert that requester's x_rvalid_o for exactly one cycle, the cycle after accept, with x_rdata_o = ram_data_i; accepted writes produce no response.
REQ-026 Back-to-back reads SHALL sustain one response per cycle; x_rdata_o SHALL be 0 when x_rvalid_o is low.
REQ-027 init_start_i high in IDLE: transition to INIT next cycle; any request in that same cycle is still granted per REQ-021.
REQ-028 INIT: both accepts low; ram_addr_o = counter, ram_data_o = 0, ram_wr_o = 8'hFF; counter starts at 0 and increments by 1 per cycle.
REQ-029 INIT: at counter = INIT_WORDS-1, write performed, init_done_o pulses in the following cycle, state returns to IDLE, counter cleared to 0.
REQ-030 init_busy_o SHALL be high exactly while state = INIT (INIT_WORDS cycles).
REQ-031 init_start_i during INIT SHALL be ignored.
REQ-032 Read accepted in cycle before INIT entry SHALL still return its rvalid during first INIT cycle.

Reset
REQ-033 rst_i high: state IDLE, counter 0, last_grant = B (A wins first contention), all rvalid and init_done_o 0, init_busy_o 0, ram_wr_o 0.
REQ-034 Reset asserted mid-INIT SHALL abort with no init_done_o pulse and drop any pending read response.

Verification
REQ-035 After reset, A and B both read (A addr 5, B addr 9) continuously -> accepts alternate A,B,A,B; each rvalid one cycle after its accept with word at its address.
REQ-036 A writes 0x1122334455667788 addr 3 wstrb 8'h0F, then reads addr 3 -> a_rdata_o low 32 bits 0x55667788, upper bytes unchanged from prior content.
REQ-037 Only B requests for 4 cycles -> b_accept_o high all 4 cycles, a_accept_o low.
REQ-038 INIT_WORDS=16, init_start_i one cycle -> init_busy_o 16 cycles, ram_wr_o 8'hFF addr 0..15, init_done_o 1 cycle after; A request during INIT stalls until IDLE.
REQ-039 rst_i asserted at INIT counter 7 -> immediate IDLE, init_busy_o 0, no init_done_o pulse; next init_start_i restarts at addr 0.
REQ-040 A read accepted in same cycle as init_start_i -> a_rvalid_o in first INIT cycle with correct data.
